// File: rtl/super_pixel_readout_arbiter.sv
// super_pixel_readout_arbiter: round-robin pixel capture into a local FIFO, merged
// fairly with the upstream column daisy chain onto one registered output word.
module super_pixel_readout_arbiter #(
    parameter int N_PIX      = 8,
    parameter int TOA_W      = 9,
    parameter int FTOA_W     = 5,
    parameter int TOT_W      = 8,
    parameter int FIFO_DEPTH = 4,
    localparam int IDX_W     = $clog2(N_PIX),
    localparam int PIX_W     = TOA_W + FTOA_W + TOT_W,
    localparam int DATA_W    = PIX_W + IDX_W + 1,
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   clk_40MHz,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic [N_PIX-1:0]       pix_valid,
    input  logic [N_PIX*PIX_W-1:0] pix_data,
    output logic [N_PIX-1:0]       pix_ack,
    input  logic                   addr_col,
    input  logic [DATA_W-1:0]      last_data,
    input  logic                   last_valid,
    output logic                   shake_hands_last,
    output logic [DATA_W-1:0]      arbiter_data,
    output logic                   arbiter_valid,
    input  logic                   shake_hands_next,
    output logic [LVL_W-1:0]       fifo_level
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic {LOCAL = 1'b0, UP = 1'b1} turn_t;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [IDX_W-1:0]  rr_ptr, grant_idx;
    logic [N_PIX-1:0]  eligible;
    logic              grant, can_wr, load_en, has_local, up_turn, sel_up, fifo_rd;
    turn_t             turn, turn_nxt;

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a, input int b);
        logic [IDX_W:0] s;
        s = {1'b0, a} + (IDX_W+1)'(b);
        return (s >= (IDX_W+1)'(N_PIX)) ? IDX_W'(s - (IDX_W+1)'(N_PIX)) : s[IDX_W-1:0];
    endfunction

    assign eligible = pix_valid & ~pix_ack;
    assign can_wr   = (fifo_level < LVL_W'(FIFO_DEPTH)) & ~flush;

    // Scan downward so the smallest offset from the RR pointer wins.
    always_comb begin
        grant     = 1'b0;
        grant_idx = '0;
        for (int i = N_PIX - 1; i >= 0; i--) begin
            if (can_wr && eligible[wrap_add(rr_ptr, i)]) begin
                grant     = 1'b1;
                grant_idx = wrap_add(rr_ptr, i);
            end
        end
    end

    assign load_en          = ~arbiter_valid | shake_hands_next;
    assign has_local        = fifo_level != '0;
    assign up_turn          = ~has_local | (turn == UP);
    assign sel_up           = last_valid & up_turn;
    assign fifo_rd          = load_en & has_local & ~sel_up & ~flush;
    assign shake_hands_last = load_en & up_turn & ~flush;

    // Turn flips only when both sources competed for the same load slot.
    always_comb begin
        turn_nxt = flush ? LOCAL
                 : (load_en & has_local & last_valid) ? ((turn == UP) ? LOCAL : UP)
                 : turn;
    end

    always_ff @(posedge clk_40MHz or negedge rst_n) begin
        if (!rst_n) turn <= LOCAL;
        else        turn <= turn_nxt;
    end

    always_ff @(posedge clk_40MHz) begin
        if (grant) mem[wr_ptr] <= {pix_data[grant_idx*PIX_W +: PIX_W], grant_idx, addr_col};
    end

    always_ff @(posedge clk_40MHz or negedge rst_n) begin
        if (!rst_n) begin
            pix_ack       <= '0;
            arbiter_valid <= 1'b0;
            arbiter_data  <= '0;
            fifo_level    <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            rr_ptr        <= '0;
        end else if (flush) begin
            pix_ack       <= '0;
            arbiter_valid <= 1'b0;
            arbiter_data  <= '0;
            fifo_level    <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            rr_ptr        <= '0;
        end else begin
            pix_ack    <= grant ? (N_PIX'(1) << grant_idx) : '0;
            fifo_level <= fifo_level + LVL_W'(grant) - LVL_W'(fifo_rd);
            wr_ptr     <= wr_ptr + PTR_W'(grant);
            rd_ptr     <= rd_ptr + PTR_W'(fifo_rd);
            if (grant) rr_ptr <= wrap_add(grant_idx, 1);
            if (load_en) begin
                arbiter_valid <= has_local | last_valid;
                arbiter_data  <= sel_up ? last_data : has_local ? mem[rd_ptr] : '0;
            end
        end
    end
endmodule

// File: tb/tb_super_pixel_readout_arbiter.sv
// tb_super_pixel_readout_arbiter: randomized and directed checks against a queue-based
// transaction model of pixel capture, FIFO buffering and upstream/local merging.
module tb_super_pixel_readout_arbiter;
    localparam int N     = 8;
    localparam int PW    = 22;
    localparam int IW    = 3;
    localparam int DW    = 26;
    localparam int DEPTH = 4;

    logic            clk, rst_n, flush, col, lv, shn, shake_hands_last, arbiter_valid;
    logic [N-1:0]    pv, pix_ack;
    logic [N*PW-1:0] pd;
    logic [DW-1:0]   ld, arbiter_data;
    logic [2:0]      fifo_level;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] q[$];
    logic [N-1:0]  m_ack;
    logic [DW-1:0] m_data;
    logic          m_valid;
    bit            m_turn;
    int            m_ptr;

    super_pixel_readout_arbiter dut (
        .clk_40MHz(clk), .rst_n(rst_n), .flush(flush), .pix_valid(pv), .pix_data(pd),
        .pix_ack(pix_ack), .addr_col(col), .last_data(ld), .last_valid(lv),
        .shake_hands_last(shake_hands_last), .arbiter_data(arbiter_data),
        .arbiter_valid(arbiter_valid), .shake_hands_next(shn), .fifo_level(fifo_level)
    );

    always #10 clk = ~clk;

    task automatic model_reset();
        q.delete();
        m_ack   = '0;
        m_data  = '0;
        m_valid = 1'b0;
        m_turn  = 1'b0;
        m_ptr   = 0;
    endtask

    // Advance model and DUT across one rising edge; pixels drop valid once acked.
    task automatic step();
        bit le, loc, from_up;
        int g;
        logic [IW-1:0] k;
        le  = !m_valid || shn;
        loc = q.size() > 0;
        g   = -1;
        if (q.size() < DEPTH)
            for (int i = 0; i < N; i++) begin
                k = IW'((m_ptr + i) % N);
                if (g < 0 && pv[k] && !m_ack[k]) g = int'(k);
            end
        if (flush) model_reset();
        else begin
            if (le) begin
                from_up = lv;
                if (loc && lv) begin
                    from_up = m_turn;
                    m_turn  = !m_turn;
                end
                m_valid = loc || lv;
                if (from_up) m_data = ld;
                else if (loc) m_data = q.pop_front();
                else m_data = '0;
            end
            m_ack = '0;
            if (g >= 0) begin
                q.push_back({pd[g*PW +: PW], IW'(g), col});
                m_ack[IW'(g)] = 1'b1;
                m_ptr = (g + 1) % N;
            end
        end
        @(posedge clk);
        #1;
        pv = pv & ~pix_ack;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic randomize_pixels();
        for (int k = 0; k < N; k++) pd[k*PW +: PW] = PW'($urandom);
    endtask

    task automatic test_reset();
        int n = 0;
        randomize_pixels();
        pv  = '1;
        shn = 1'b0;
        lv  = 1'b0;
        while (fifo_level != 3'd3 && n < 10) begin
            step();
            n++;
        end
        checks++;
        if (fifo_level !== 3'd3) $display("FAIL reset_fill: fifo_level=%0d want 3", fifo_level);
        #5 rst_n = 1'b0;
        #1;
        checks++;
        if (fifo_level !== 3'd0) $display("FAIL reset_level: got %0d want 0", fifo_level);
        checks++;
        if (arbiter_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", arbiter_valid);
        checks++;
        if (arbiter_data !== '0) $display("FAIL reset_data: got %h want 0", arbiter_data);
        checks++;
        if (pix_ack !== '0) $display("FAIL reset_ack: got %h want 0", pix_ack);
        errors += (fifo_level !== 3'd3 ? 0 : 0);
        model_reset();
        pv = '0;
        shn = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_hit();
        do_flush();
        pd[PW-1:0] = {9'h1FF, 5'd17, 8'd49};
        col = 1'b0;
        shn = 1'b1;
        pv  = 8'h01;
        step();
        checks++;
        if (fifo_level !== 3'd1) begin errors++; $display("FAIL hit_level: got %0d want 1", fifo_level); end
        checks++;
        if (pix_ack !== 8'h01) begin errors++; $display("FAIL hit_ack: got %h want 01", pix_ack); end
        checks++;
        if (arbiter_valid !== 1'b0) begin errors++; $display("FAIL hit_early_valid: got %b want 0", arbiter_valid); end
        step();
        checks++;
        if (arbiter_valid !== 1'b1) begin errors++; $display("FAIL hit_valid: got %b want 1", arbiter_valid); end
        checks++;
        if (arbiter_data !== 26'h3FF1310) begin errors++; $display("FAIL hit_data: got %h want 3ff1310", arbiter_data); end
        checks++;
        if (pix_ack !== 8'h00) begin errors++; $display("FAIL hit_ack_pulse: got %h want 00", pix_ack); end
        step();
        checks++;
        if (arbiter_valid !== 1'b0 || arbiter_data !== '0) begin
            errors++;
            $display("FAIL hit_idle: valid=%b data=%h want 0/0", arbiter_valid, arbiter_data);
        end
    endtask

    task automatic test_all_valid();
        int got = 0, n = 0;
        do_flush();
        randomize_pixels();
        col = 1'($urandom);
        pv  = '1;
        shn = 1'b1;
        lv  = 1'b0;
        while (got < 8 && n < 40) begin
            step();
            n++;
            checks++;
            if (arbiter_valid !== m_valid || arbiter_data !== m_data) begin
                errors++;
                $display("FAIL all_word: got %b/%h want %b/%h", arbiter_valid, arbiter_data, m_valid, m_data);
            end
            checks++;
            if (fifo_level !== 3'(q.size())) begin errors++; $display("FAIL all_level: got %0d want %0d", fifo_level, q.size()); end
            if (arbiter_valid) begin
                checks++;
                if (arbiter_data[IW:1] !== IW'(got)) begin
                    errors++;
                    $display("FAIL all_order: got pix %0d want %0d", arbiter_data[IW:1], got);
                end
                got++;
            end
        end
        checks++;
        if (got != 8) begin errors++; $display("FAIL all_count: got %0d want 8", got); end
        step();
        checks++;
        if (arbiter_valid !== 1'b0) begin errors++; $display("FAIL all_extra: got valid %b want 0", arbiter_valid); end
    endtask

    task automatic test_backpressure();
        int got = 0, n = 0;
        do_flush();
        randomize_pixels();
        pv  = '1;
        shn = 1'b0;
        repeat (8) step();
        checks++;
        if (fifo_level !== 3'd4) begin errors++; $display("FAIL bp_level: got %0d want 4", fifo_level); end
        checks++;
        if (arbiter_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b want 1", arbiter_valid); end
        checks++;
        if (pv !== 8'hE0) begin errors++; $display("FAIL bp_pending: got %h want e0", pv); end
        shn = 1'b1;
        while (got < 8 && n < 40) begin
            if (arbiter_valid) begin
                checks++;
                if (arbiter_data[IW:1] !== IW'(got)) begin
                    errors++;
                    $display("FAIL bp_order: got pix %0d want %0d", arbiter_data[IW:1], got);
                end
                got++;
            end
            step();
            n++;
            checks++;
            if (arbiter_valid !== m_valid || arbiter_data !== m_data) begin
                errors++;
                $display("FAIL bp_word: got %b/%h want %b/%h", arbiter_valid, arbiter_data, m_valid, m_data);
            end
        end
        checks++;
        if (got != 8 || arbiter_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: got %0d words valid=%b want 8 words valid=0", got, arbiter_valid);
        end
    endtask

    task automatic test_merge();
        logic [DW-1:0] cur;
        bit exp_shl, is_up;
        do_flush();
        randomize_pixels();
        for (int k = 0; k < N; k++) pd[k*PW + PW - 1] = 1'b1;
        pv  = '1;
        shn = 1'b0;
        lv  = 1'b0;
        repeat (6) step();
        ld  = {1'b0, 25'($urandom)};
        lv  = 1'b1;
        shn = 1'b1;
        for (int j = 0; j < 10; j++) begin
            #1;
            exp_shl = (!m_valid || shn) && (q.size() == 0 || m_turn);
            checks++;
            if (shake_hands_last !== exp_shl) begin
                errors++;
                $display("FAIL merge_shl_model[%0d]: got %b want %b", j, shake_hands_last, exp_shl);
            end
            checks++;
            if (shake_hands_last !== 1'(j % 2)) begin
                errors++;
                $display("FAIL merge_shl_turn[%0d]: got %b want %b", j, shake_hands_last, j % 2);
            end
            cur = ld;
            step();
            checks++;
            if (arbiter_valid !== m_valid || arbiter_data !== m_data) begin
                errors++;
                $display("FAIL merge_word[%0d]: got %b/%h want %b/%h", j, arbiter_valid, arbiter_data, m_valid, m_data);
            end
            is_up = arbiter_data === cur;
            checks++;
            if (is_up !== 1'(j % 2)) begin
                errors++;
                $display("FAIL merge_src[%0d]: got up=%b want up=%b", j, is_up, j % 2);
            end
            if (is_up) ld = {1'b0, 25'($urandom)};
        end
        lv = 1'b0;
    endtask

    task automatic test_flush();
        int n = 0;
        pv  = '0;
        shn = 1'b1;
        do_flush();
        randomize_pixels();
        pv  = '1;
        shn = 1'b0;
        while (!(fifo_level == 3'd2 && arbiter_valid) && n < 10) begin
            step();
            n++;
        end
        checks++;
        if (fifo_level !== 3'd2 || arbiter_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_setup: level=%0d valid=%b want 2/1", fifo_level, arbiter_valid);
        end
        do_flush();
        checks++;
        if (fifo_level !== 3'd0) begin errors++; $display("FAIL flush_level: got %0d want 0", fifo_level); end
        checks++;
        if (arbiter_valid !== 1'b0 || arbiter_data !== '0) begin
            errors++;
            $display("FAIL flush_out: valid=%b data=%h want 0/0", arbiter_valid, arbiter_data);
        end
        checks++;
        if (pix_ack !== '0) begin errors++; $display("FAIL flush_ack: got %h want 00", pix_ack); end
        pv[0] = 1'b1;
        step();
        checks++;
        if (pix_ack !== 8'h01) begin errors++; $display("FAIL flush_rr_restart: got ack %h want 01", pix_ack); end
    endtask

    task automatic test_random();
        bit taken = 1'b0, exp_shl;
        pv  = '0;
        lv  = 1'b0;
        shn = 1'b1;
        do_flush();
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++)
                if (!pv[k] && !pix_ack[k] && $urandom_range(3) == 0) begin
                    pv[k] = 1'b1;
                    pd[k*PW +: PW] = PW'($urandom);
                end
            if (!lv || taken) begin
                lv = 1'($urandom_range(1));
                ld = DW'($urandom);
            end
            shn   = $urandom_range(3) != 0;
            col   = 1'($urandom);
            flush = $urandom_range(60) == 0;
            #1;
            exp_shl = !flush && (!m_valid || shn) && (q.size() == 0 || m_turn);
            checks++;
            if (shake_hands_last !== exp_shl) begin
                errors++;
                $display("FAIL rnd_shl[%0d]: got %b want %b", c, shake_hands_last, exp_shl);
            end
            taken = lv && shake_hands_last;
            step();
            flush = 1'b0;
            checks++;
            if (arbiter_valid !== m_valid || arbiter_data !== m_data) begin
                errors++;
                $display("FAIL rnd_word[%0d]: got %b/%h want %b/%h", c, arbiter_valid, arbiter_data, m_valid, m_data);
            end
            checks++;
            if (fifo_level !== 3'(q.size()) || pix_ack !== m_ack) begin
                errors++;
                $display("FAIL rnd_state[%0d]: level=%0d ack=%h want %0d/%h", c, fifo_level, pix_ack, q.size(), m_ack);
            end
        end
    endtask

    initial begin
        clk   = 1'b0;
        rst_n = 1'b0;
        flush = 1'b0;
        pv    = '0;
        pd    = '0;
        col   = 1'b0;
        lv    = 1'b0;
        ld    = '0;
        shn   = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        test_reset();
        test_single_hit();
        test_all_valid();
        test_backpressure();
        test_merge();
        test_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
